// File: rtl/poly_add_ctrl_if.sv
// rtl/poly_add_ctrl_if.sv - memory, adder and command signals of the polynomial add controller
interface poly_add_ctrl_if #(
    parameter int AW = 10
);
    logic          start;
    logic          lazy;
    logic          hold;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data_a;
    logic [15:0]   rd_data_b;
    logic          add_en;
    logic          add_lazy;
    logic [15:0]   add_a;
    logic [15:0]   add_a_pair;
    logic [15:0]   add_b;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;

    modport master (
        output start, lazy, hold, rd_data_a, rd_data_b, add_b,
        input  busy, done, rd_en, rd_addr, add_en, add_lazy, add_a, add_a_pair,
               wr_en, wr_addr, wr_data
    );

    modport slave (
        input  start, lazy, hold, rd_data_a, rd_data_b, add_b,
        output busy, done, rd_en, rd_addr, add_en, add_lazy, add_a, add_a_pair,
               wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/poly_add_ctrl.sv
// rtl/poly_add_ctrl.sv - sequences N reads through an external 2-stage adder into a destination bank
module poly_add_ctrl #(
    parameter int N  = 1024,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          reset,
    poly_add_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [AW-1:0]       count_q, count_d;
    logic                lazy_q, lazy_d;
    // index 0 = memory stage, 1 = adder input stage, 2 = adder output stage
    logic [2:0]          vld_q, vld_d;
    logic [2:0][AW-1:0]  addr_q, addr_d;

    logic run, drain, issue, advance, last;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        lazy_d  = lazy_q;
        vld_d   = vld_q;
        addr_d  = addr_q;

        run     = (state_q == S_RUN);
        drain   = (state_q == S_DRAIN);
        issue   = run && !bus.hold;
        advance = (run || drain) && !bus.hold;
        last    = (count_q == AW'(N - 1));

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.hold) begin
                    lazy_d  = bus.lazy;
                    count_d = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!bus.hold) begin
                    if (last) begin
                        state_d = S_DRAIN;
                    end else begin
                        count_d = count_q + AW'(1);
                    end
                end
            end
            S_DRAIN: begin
                // only the final write remains in flight
                if (!bus.hold && vld_q == 3'b100) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!bus.hold) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            vld_d  = {vld_q[1:0], issue};
            addr_d = {addr_q[1:0], count_q};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            lazy_q  <= 1'b0;
            vld_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lazy_q  <= lazy_d;
            vld_q   <= vld_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.rd_en      = issue;
    assign bus.rd_addr    = count_q;
    assign bus.add_en     = advance;
    assign bus.add_lazy   = lazy_q;
    assign bus.add_a      = bus.rd_data_a;
    assign bus.add_a_pair = bus.rd_data_b;
    assign bus.wr_en      = vld_q[2] && !bus.hold;
    assign bus.wr_addr    = addr_q[2];
    assign bus.wr_data    = bus.add_b;
    assign bus.busy       = run || drain;
    assign bus.done       = (state_q == S_DONE);
endmodule
